// File: rtl/sump_tx_serializer_if.sv
// ============================================================================
// Module   : sump_tx_serializer_if
// Brief    : Sample-word, reply-request and UART byte handshake bundle for the
//            SUMP return-path serializer. meta_req_i exists only when
//            LOGIP_TX_METADATA_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sump_tx_serializer_if;
    logic [31:0] data_i;
    logic        data_valid_i;
    logic        data_ready_o;
    logic [3:0]  group_dis_i;
    logic        id_req_i;
`ifdef LOGIP_TX_METADATA_EN
    logic        meta_req_i;
`endif
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        busy_o;

`ifdef LOGIP_TX_METADATA_EN
    modport slave (
        input  data_i, data_valid_i, group_dis_i, id_req_i, meta_req_i, tx_ready_i,
        output data_ready_o, tx_data_o, tx_valid_o, busy_o
    );
    modport master (
        output data_i, data_valid_i, group_dis_i, id_req_i, meta_req_i, tx_ready_i,
        input  data_ready_o, tx_data_o, tx_valid_o, busy_o
    );
`else
    modport slave (
        input  data_i, data_valid_i, group_dis_i, id_req_i, tx_ready_i,
        output data_ready_o, tx_data_o, tx_valid_o, busy_o
    );
    modport master (
        output data_i, data_valid_i, group_dis_i, id_req_i, tx_ready_i,
        input  data_ready_o, tx_data_o, tx_valid_o, busy_o
    );
`endif

endinterface

`default_nettype wire

// File: rtl/sump_tx_serializer.sv
// ============================================================================
// Module   : sump_tx_serializer
// Brief    : Serializes 32-bit sample words (with group-disable mask) and SUMP
//            ID / metadata replies into a byte stream for the UART TX.
//            Optional metadata reply: define LOGIP_TX_METADATA_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sump_tx_serializer #(
    parameter int SAMPLE_WIDTH = 32,
    parameter int MEM_DEPTH    = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_in,
    sump_tx_serializer_if.slave  bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_DATA = 2'd1;
    localparam logic [1:0] c_ST_ID   = 2'd2;
`ifdef LOGIP_TX_METADATA_EN
    localparam logic [1:0] c_ST_META   = 2'd3;
    localparam logic [3:0] c_META_LAST = 4'd12;
    localparam logic [31:0] c_DEPTH_BYTES = 32'(MEM_DEPTH * 4);
`endif

    // Byte lanes are hard-wired to four groups of eight bits.
    if (SAMPLE_WIDTH != 32 || MEM_DEPTH < 1) begin : g_bad_cfg
        $error("sump_tx_serializer: SAMPLE_WIDTH must be 32 and MEM_DEPTH positive");
    end

    logic [1:0]  r_state;
    logic [1:0]  r_idx;
    logic [31:0] r_word;
    logic [3:0]  r_dis;
    logic        r_id_pend;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
`ifdef LOGIP_TX_METADATA_EN
    logic        r_meta_pend;
    logic [3:0]  r_meta_idx;
`endif

    logic        w_any_pend;
    logic        w_tx_fire;
    logic [1:0]  w_first_idx;
    logic [1:0]  w_next_idx;
    logic        w_next_found;
    logic [1:0]  w_idx_inc;

    function automatic logic [7:0] f_word_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] f_id_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h31;
            2'd1:    return 8'h41;
            2'd2:    return 8'h4C;
            default: return 8'h53;
        endcase
    endfunction

`ifdef LOGIP_TX_METADATA_EN
    // Metadata reply: device name "logIP", sample memory size in bytes, end marker.
    function automatic logic [7:0] f_meta_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h6C;
            4'd2:    return 8'h6F;
            4'd3:    return 8'h67;
            4'd4:    return 8'h49;
            4'd5:    return 8'h50;
            4'd6:    return 8'h00;
            4'd7:    return 8'h21;
            4'd8:    return c_DEPTH_BYTES[31:24];
            4'd9:    return c_DEPTH_BYTES[23:16];
            4'd10:   return c_DEPTH_BYTES[15:8];
            4'd11:   return c_DEPTH_BYTES[7:0];
            default: return 8'h00;
        endcase
    endfunction

    assign w_any_pend = r_id_pend | r_meta_pend;
`else
    assign w_any_pend = r_id_pend;
`endif

    assign w_tx_fire = r_tx_valid & bus.tx_ready_i;
    assign w_idx_inc = r_idx + 2'd1;

    // Lowest enabled group of the incoming word; only meaningful when not all disabled.
    always_comb begin
        w_first_idx = 2'd0;
        for (int g = 3; g >= 0; g--) begin
            if (!bus.group_dis_i[g]) begin
                w_first_idx = 2'(g);
            end
        end
    end

    // Next enabled group strictly above the current one; no wrap past group 3.
    always_comb begin
        w_next_found = 1'b0;
        w_next_idx   = r_idx;
        for (int g = 3; g >= 1; g--) begin
            if (g > int'(r_idx) && !r_dis[g]) begin
                w_next_found = 1'b1;
                w_next_idx   = 2'(g);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= c_ST_IDLE;
            r_idx      <= 2'd0;
            r_word     <= 32'd0;
            r_dis      <= 4'd0;
            r_id_pend  <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
`ifdef LOGIP_TX_METADATA_EN
            r_meta_pend <= 1'b0;
            r_meta_idx  <= 4'd0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_id_pend) begin
                        r_state   <= c_ST_ID;
                        r_id_pend <= 1'b0;
                        r_idx     <= 2'd0;
`ifdef LOGIP_TX_METADATA_EN
                    end else if (r_meta_pend) begin
                        r_state     <= c_ST_META;
                        r_meta_pend <= 1'b0;
                        r_meta_idx  <= 4'd0;
`endif
                    end else if (bus.data_valid_i) begin
                        r_word <= bus.data_i;
                        r_dis  <= bus.group_dis_i;
                        r_idx  <= w_first_idx;
                        if (bus.group_dis_i != 4'hF) begin
                            r_state <= c_ST_DATA;
                        end
                    end
                end

                c_ST_DATA: begin
                    if (!r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= f_word_byte(r_word, r_idx);
                    end else if (w_tx_fire) begin
                        if (w_next_found) begin
                            r_idx     <= w_next_idx;
                            r_tx_data <= f_word_byte(r_word, w_next_idx);
                        end else begin
                            r_tx_valid <= 1'b0;
                            r_state    <= c_ST_IDLE;
                        end
                    end
                end

                c_ST_ID: begin
                    if (!r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= f_id_byte(r_idx);
                    end else if (w_tx_fire) begin
                        if (r_idx == 2'd3) begin
                            r_tx_valid <= 1'b0;
                            r_state    <= c_ST_IDLE;
                        end else begin
                            r_idx     <= w_idx_inc;
                            r_tx_data <= f_id_byte(w_idx_inc);
                        end
                    end
                end

`ifdef LOGIP_TX_METADATA_EN
                c_ST_META: begin
                    if (!r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= f_meta_byte(r_meta_idx);
                    end else if (w_tx_fire) begin
                        if (r_meta_idx == c_META_LAST) begin
                            r_tx_valid <= 1'b0;
                            r_state    <= c_ST_IDLE;
                        end else begin
                            r_meta_idx <= r_meta_idx + 4'd1;
                            r_tx_data  <= f_meta_byte(r_meta_idx + 4'd1);
                        end
                    end
                end
`endif

                default: begin
                    r_tx_valid <= 1'b0;
                    r_state    <= c_ST_IDLE;
                end
            endcase

            // Placed after the state logic so a pulse landing on the clearing cycle is kept.
            if (bus.id_req_i) begin
                r_id_pend <= 1'b1;
            end
`ifdef LOGIP_TX_METADATA_EN
            if (bus.meta_req_i) begin
                r_meta_pend <= 1'b1;
            end
`endif
        end
    end

    assign bus.data_ready_o = rst_in & (r_state == c_ST_IDLE) & ~w_any_pend;
    assign bus.busy_o       = (r_state != c_ST_IDLE) | w_any_pend;
    assign bus.tx_data_o    = r_tx_data;
    assign bus.tx_valid_o   = r_tx_valid;

endmodule

`default_nettype wire

// File: tb/tb_sump_tx_serializer.sv
// ============================================================================
// Module   : tb_sump_tx_serializer
// Brief    : Directed self-checking bench for sump_tx_serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sump_tx_serializer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;
    bit   rnd_rdy = 1'b0;

    logic [7:0] q[$];
    logic [7:0] exp_q[$];
    int         v_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    sump_tx_serializer_if bus();

    sump_tx_serializer #(
        .SAMPLE_WIDTH (32),
        .MEM_DEPTH    (4096)
    ) dut (
        .clk_i  (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Byte collector and hold-stable monitor on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall)
                chk("hold", {23'd0, bus.tx_valid_o, bus.tx_data_o}, {23'd0, 1'b1, prev_data});
            if (bus.tx_valid_o) v_cnt <= v_cnt + 1;
            if (bus.tx_valid_o && bus.tx_ready_i) q.push_back(bus.tx_data_o);
            prev_stall <= bus.tx_valid_o && !bus.tx_ready_i;
            prev_data  <= bus.tx_data_o;
        end
    end

    // UART ready: always high, or random stalls of 1..20 cycles.
    initial begin
        int stall = 0;
        bus.tx_ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!rnd_rdy) begin
                bus.tx_ready_i = 1'b1;
                stall = 0;
            end else if (stall > 0) begin
                bus.tx_ready_i = 1'b0;
                stall--;
            end else if ($urandom_range(0, 2) == 0) begin
                stall = int'($urandom_range(1, 20)) - 1;
                bus.tx_ready_i = 1'b0;
            end else begin
                bus.tx_ready_i = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    task automatic pulse_id();
        tick(); bus.id_req_i = 1'b1;
        tick(); bus.id_req_i = 1'b0;
    endtask

    task automatic send_word(input string tag, input logic [31:0] d, input logic [3:0] dis);
        bit ok = 1'b0;
        tick();
        bus.data_valid_i = 1'b1;
        bus.data_i       = d;
        bus.group_dis_i  = dis;
        for (int i = 0; i < 600 && !ok; i++) begin
            sample();
            ok = bus.data_ready_o;
        end
        chk({tag, "_accept"}, 32'(ok), 32'd1);
        tick();
        bus.data_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output bit rdy_seen);
        int i = 0;
        rdy_seen = 1'b0;
        do begin
            sample();
            if (bus.busy_o && bus.data_ready_o) rdy_seen = 1'b1;
            i++;
        end while ((bus.busy_o || bus.tx_valid_o) && i < 600);
        chk({tag, "_idle"}, 32'(bus.busy_o), 32'd0);
    endtask

    task automatic wait_bytes(input string tag, input int n);
        int i = 0;
        while (q.size() < n && i < 200) begin
            sample();
            i++;
        end
        chk({tag, "_reach"}, 32'(q.size() >= n), 32'd1);
    endtask

    function automatic void add_word(input logic [31:0] w, input logic [3:0] dis);
        for (int g = 0; g < 4; g++)
            if (!dis[g]) exp_q.push_back(w[8*g +: 8]);
    endfunction

    task automatic cmp_q(input string tag);
        chk({tag, "_len"}, 32'(q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), 32'(q[i]), 32'(exp_q[i]));
        q.delete();
        exp_q.delete();
    endtask

    logic [31:0] rw_data [8] = '{32'hDEADBEEF, 32'h12345678, 32'h0BADF00D, 32'hCAFEBABE,
                                 32'h00FF00FF, 32'h89ABCDEF, 32'h13579BDF, 32'h2468ACE0};
    logic [3:0]  rw_dis  [8] = '{4'h0, 4'h5, 4'h8, 4'h1, 4'h6, 4'hE, 4'h0, 4'h7};

    initial begin
        bit seen;
        int v0;
        bit ok;

        bus.data_i       = 32'd0;
        bus.data_valid_i = 1'b0;
        bus.group_dis_i  = 4'd0;
        bus.id_req_i     = 1'b0;
`ifdef LOGIP_TX_METADATA_EN
        bus.meta_req_i   = 1'b0;
`endif

        // Reset values
        repeat (3) sample();
        chk("rst_valid", 32'(bus.tx_valid_o), 32'd0);
        chk("rst_data",  32'(bus.tx_data_o),  32'd0);
        chk("rst_ready", 32'(bus.data_ready_o), 32'd0);
        chk("rst_busy",  32'(bus.busy_o), 32'd0);
        tick(); rst_n = 1'b1;
        sample();
        chk("idle_ready", 32'(bus.data_ready_o), 32'd1);

        // ID reply
        pulse_id();
        sample();
        chk("id_busy", 32'(bus.busy_o), 32'd1);
        wait_idle("id", seen);
        exp_q = '{8'h31, 8'h41, 8'h4C, 8'h53};
        cmp_q("id");

        // Full word, all groups enabled; no new word accepted until done
        send_word("w1", 32'hDEADBEEF, 4'h0);
        wait_idle("w1", seen);
        chk("w1_rdy_low", 32'(seen), 32'd0);
        chk("w1_rdy_after", 32'(bus.data_ready_o), 32'd1);
        exp_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        cmp_q("w1");

        // Groups 1 and 3 disabled
        send_word("w2", 32'h12345678, 4'b1010);
        wait_idle("w2", seen);
        exp_q = '{8'h78, 8'h34};
        cmp_q("w2");

        // All groups disabled: consumed silently
        v0 = v_cnt;
        send_word("wf", 32'hAABBCCDD, 4'hF);
        repeat (5) sample();
        chk("wf_valid_cnt", 32'(v_cnt - v0), 32'd0);
        chk("wf_len", 32'(q.size()), 32'd0);
        chk("wf_busy", 32'(bus.busy_o), 32'd0);

        // Eight words under random back-pressure
        rnd_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send_word($sformatf("rw%0d", k), rw_data[k], rw_dis[k]);
            add_word(rw_data[k], rw_dis[k]);
        end
        wait_idle("rw", seen);
        rnd_rdy = 1'b0;
        repeat (2) tick();
        cmp_q("rw");

        // ID request (pulsed twice, merged) during a word; next word waits
        send_word("mw", 32'h01020304, 4'h0);
        wait_bytes("mw", 1);
        pulse_id();
        pulse_id();
        bus.data_valid_i = 1'b1;
        bus.data_i       = 32'h0A0B0C0D;
        bus.group_dis_i  = 4'h0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            sample();
            ok = bus.data_ready_o;
        end
        chk("mw_next_accept", 32'(ok), 32'd1);
        chk("mw_q_at_accept", 32'(q.size()), 32'd8);
        tick();
        bus.data_valid_i = 1'b0;
        wait_idle("mw", seen);
        exp_q = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h31, 8'h41, 8'h4C, 8'h53,
                  8'h0D, 8'h0C, 8'h0B, 8'h0A};
        cmp_q("mw");

        // Reset mid-word
        send_word("rs", 32'h11223344, 4'h0);
        wait_bytes("rs", 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rs_valid", 32'(bus.tx_valid_o), 32'd0);
        chk("rs_busy",  32'(bus.busy_o), 32'd0);
        exp_q = '{8'h44, 8'h33};
        cmp_q("rs_pre");
        repeat (2) tick();
        rst_n = 1'b1;
        sample();
        chk("rs_clean", 32'(bus.busy_o), 32'd0);
        pulse_id();
        wait_idle("rs_id", seen);
        exp_q = '{8'h31, 8'h41, 8'h4C, 8'h53};
        cmp_q("rs_id");

`ifdef LOGIP_TX_METADATA_EN
        tick(); bus.meta_req_i = 1'b1;
        tick(); bus.meta_req_i = 1'b0;
        wait_idle("meta", seen);
        exp_q = '{8'h01, 8'h6C, 8'h6F, 8'h67, 8'h49, 8'h50, 8'h00, 8'h21,
                  8'h00, 8'h00, 8'h40, 8'h00, 8'h00};
        cmp_q("meta");
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/sump_tx_serializer.md
Name: sump_tx_serializer

Overview:
Return-path counterpart to the SUMP command decoder. Accepts 32-bit sample words from the readout path and SUMP reply requests (ID, optionally metadata), then serializes them into a byte stream for the UART transmitter. Applies the channel-group disable mask set by the decoder's flags command.
- Sits between the sample memory readout and the UART TX.

Parameters:
- SAMPLE_WIDTH, 32: sample word width; fixed to 4 byte groups.
- MEM_DEPTH, 4096: sample memory depth in samples; reported in metadata only.

Ports:
- clk_i  in  1  system clock
- rst_in  in  1  asynchronous active-low reset
- data_i  in  32  sample word
- data_valid_i  in  1  sample word valid
- data_ready_o  out  1  sample word accepted when valid and ready are both high
- group_dis_i  in  4  bit n high: skip byte n (data_i[8n+7:8n]); sampled when a word is accepted
- id_req_i  in  1  single-cycle pulse: send ID reply
- meta_req_i  in  1  single-cycle pulse: send metadata; present only with LOGIP_TX_METADATA_EN
- tx_data_o  out  8  byte to UART
- tx_valid_o  out  1  byte valid
- tx_ready_i  in  1  UART accepts byte when valid and ready are both high
- busy_o  out  1  high while not in IDLE or a request is pending

Behaviour:
- Reset (rst_in low, async): state IDLE, tx_valid_o=0, tx_data_o=0x00, data_ready_o=0, busy_o=0, pending flags cleared, byte index 0.
- States: IDLE, DATA, ID, META.
- Request latching: id_req_i/meta_req_i pulses set pending flags in any state. A repeated pulse while a flag is already pending is merged.
- IDLE priority: pending ID > pending META > data.
- data_ready_o=1 only in IDLE with no pending flag (registered-state decode, combinational output).
- ID request: go to ID. Clear ID pending flag. Emit 0x31 '1', 0x41 'A', 0x4C 'L', 0x53 'S' in that order.
- Data handshake in IDLE: latch data_i and group_dis_i.
  - Go to DATA; emit enabled bytes in ascending group order (byte 0 first).
  - If group_dis_i=4'hF, the word is consumed with no output and the block stays IDLE.
- Byte output is registered:
  - tx_valid_o rises the cycle after entering a sending state.
  - Holds tx_data_o stable until the tx handshake.
  - After a handshake, the next byte is presented the following cycle. Back-to-back throughput is 1 byte per 2 cycles minimum; gapless streaming is not required.
  - tx_valid_o never drops without a handshake.
- After the last byte's handshake: return to IDLE. tx_valid_o=0 that cycle.
- An ID or META request arriving mid-word does not interrupt the word; it is served after.
- tx_ready_i held low indefinitely: block stalls and data_ready_o stays 0. No bytes are dropped or reordered.
- Reset mid-transfer: immediate abort. Latched word and pending flags are lost.
- Byte index counter: 2 bits. Skip logic searches the next enabled group combinationally from the current index. No wrap beyond group 3.

Optional Feature:
- Macro: LOGIP_TX_METADATA_EN
- Defined:
  - meta_req_i port exists; META state is built.
  - META sequence: 0x01, 'l','o','g','I','P', 0x00, 0x21, MEM_DEPTH*4 as 32-bit big-endian, 0x00 (end marker). Total 13 bytes.
  - Metadata sequence is held in a ROM indexed by a 4-bit counter.
- Not defined: no meta_req_i port, no META state. Metadata commands produce no reply.

Test Plan:
- Reset, then id_req_i pulse, tx_ready_i=1 -> bytes 0x31,0x41,0x4C,0x53 in order; busy_o falls after the 4th handshake.
- data_i=0xDEADBEEF, group_dis_i=4'h0 -> bytes 0xEF,0xBE,0xAD,0xDE; data_ready_o=0 until the last handshake.
- data_i=0x12345678, group_dis_i=4'b1010 -> bytes 0x78,0x34 only. Then group_dis_i=4'hF with data_i=0xAABBCCDD -> word accepted, no tx_valid_o pulse.
- tx_ready_i toggled randomly (held low up to 20 cycles) while streaming 8 words -> byte stream identical to the ready-always-high run; tx_data_o stable whenever tx_valid_o=1 and tx_ready_i=0.
- id_req_i pulsed during the 2nd byte of word 0x01020304 -> 0x04,0x03,0x02,0x01 then '1','A','L','S'. A further data word is accepted only afterwards.
- Reset asserted after the 2nd byte of a word -> tx_valid_o=0 immediately. After release, id_req_i gives a clean 4-byte ID reply. With LOGIP_TX_METADATA_EN and MEM_DEPTH=4096: meta_req_i -> 13 bytes ending 0x00,0x00,0x40,0x00,0x00.
